// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one Size-bit up-counter among several requesters.
// Each winner gets a timed run from 0 up to its latched limit, then a one-cycle done.
//
// Ports:
//   clock   system clock, all state on posedge
//   reset   asynchronous active-high reset
//   req     per-requester level request, held until done
//   limit   packed limits, requester i uses bits [i*Size +: Size]
//   cancel  global abort of the current run
//   grant   one-hot owner of the counter, zero when idle
//   busy    high while running or signalling done
//   done    one-cycle completion pulse to the owner
//   count   shared counter value
module counter_scheduler #(
  parameter int unsigned Size       = 5,
  parameter int unsigned Requesters = 4,
  parameter int unsigned IdxWidth   = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [Requesters-1:0]        req,
  input  logic [Requesters*Size-1:0]   limit,
  input  logic                         cancel,
  output logic [Requesters-1:0]        grant,
  output logic                         busy,
  output logic [Requesters-1:0]        done,
  output logic [Size-1:0]              count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [IdxWidth-1:0] ptr;
  logic [IdxWidth-1:0] owner;
  logic [Size-1:0]     lim_q;

  logic [IdxWidth-1:0] win;
  logic [IdxWidth:0]   cand;
  logic                found;
  logic [Size-1:0]     lim_sel;
  logic [IdxWidth-1:0] ptr_nxt;

  // First requesting index at or after ptr, scanning circularly.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < int'(Requesters); i++) begin
      cand = {1'b0, ptr} + (IdxWidth+1)'(i);
      if (cand >= (IdxWidth+1)'(Requesters)) begin
        cand = cand - (IdxWidth+1)'(Requesters);
      end
      if (!found && req[cand[IdxWidth-1:0]]) begin
        win   = cand[IdxWidth-1:0];
        found = 1'b1;
      end
    end
  end

  // Winner's limit and the pointer value just past the winner.
  always_comb begin
    lim_sel = '0;
    for (int i = 0; i < int'(Requesters); i++) begin
      if (IdxWidth'(i) == win) begin
        lim_sel = limit[i*Size +: Size];
      end
    end
    ptr_nxt = (win == IdxWidth'(Requesters - 1)) ? '0 : win + 1'b1;
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      lim_q <= '0;
      grant <= '0;
      busy  <= 1'b0;
      done  <= '0;
      count <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state <= RUN;
            owner <= win;
            ptr   <= ptr_nxt;
            lim_q <= lim_sel;
            grant <= Requesters'(1) << win;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        RUN: begin
          // Abort wins over completion; count is left where it stopped.
          if (cancel || !req[owner]) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end else if (count == lim_q) begin
            state <= DONE;
            grant <= '0;
            done  <= Requesters'(1) << owner;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler: table-driven single runs plus
// hand-written sequences, with per-cycle expected snapshots queued and popped.
module tb_counter_scheduler;

  localparam int unsigned Size       = 5;
  localparam int unsigned Requesters = 4;
  localparam int unsigned IdxWidth   = 2;

  logic                       clock;
  logic                       reset;
  logic [Requesters-1:0]      req;
  logic [Requesters*Size-1:0] limit;
  logic                       cancel;
  logic [Requesters-1:0]      grant;
  logic                       busy;
  logic [Requesters-1:0]      done;
  logic [Size-1:0]            count;

  counter_scheduler #(
    .Size(Size), .Requesters(Requesters), .IdxWidth(IdxWidth)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .limit(limit), .cancel(cancel),
    .grant(grant), .busy(busy), .done(done), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] grant;
    logic       busy;
    logic [3:0] done;
    logic [4:0] count;
  } snap_t;

  typedef struct {
    int         idx;
    logic [4:0] lim;
    logic [3:0] onehot;
    int         run_cycles;
  } vec_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  vecs[5];

  function automatic snap_t mk(logic [3:0] g, logic b, logic [3:0] d, logic [4:0] c);
    snap_t s;
    s.grant = g; s.busy = b; s.done = d; s.count = c;
    return s;
  endfunction

  task automatic check(input string name, input snap_t e);
    snap_t a;
    a = mk(grant, busy, done, count);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got grant=%b busy=%b done=%b count=%0d, want grant=%b busy=%b done=%b count=%0d",
               name, a.grant, a.busy, a.done, a.count, e.grant, e.busy, e.done, e.count);
    end
  endtask

  // Expected cycles of one complete run followed by one idle cycle.
  task automatic push_run(input logic [3:0] oh, input logic [4:0] lim, input int run_cycles);
    for (int k = 0; k < run_cycles; k++) exp_q.push_back(mk(oh, 1'b1, 4'b0, 5'(k)));
    exp_q.push_back(mk(4'b0, 1'b1, oh, lim));
    exp_q.push_back(mk(4'b0, 1'b0, 4'b0, lim));
  endtask

  // Advance one cycle per queued snapshot and compare at the falling edge.
  task automatic drain(input string name, input bit keep_req, input bit scramble);
    int n;
    snap_t s;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      s = exp_q.pop_front();
      check($sformatf("%s[%0d]", name, i), s);
      if (!keep_req && s.done != 4'b0) req = req & ~s.done;
      if (scramble && i == 0) limit = 20'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    req    = '0;
    limit  = '0;
    cancel = 1'b0;

    vecs[0] = '{idx: 0, lim: 5'd3,  onehot: 4'b0001, run_cycles: 4};
    vecs[1] = '{idx: 2, lim: 5'd0,  onehot: 4'b0100, run_cycles: 1};
    vecs[2] = '{idx: 1, lim: 5'd31, onehot: 4'b0010, run_cycles: 32};
    vecs[3] = '{idx: 3, lim: 5'd5,  onehot: 4'b1000, run_cycles: 6};
    vecs[4] = '{idx: 0, lim: 5'd1,  onehot: 4'b0001, run_cycles: 2};

    @(negedge clock);
    check("reset_state", mk(4'b0, 1'b0, 4'b0, 5'd0));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("idle_no_req", mk(4'b0, 1'b0, 4'b0, 5'd0));

    // Single runs; limits are scrambled after the grant to show they were latched.
    for (int v = 0; v < 5; v++) begin
      limit = '0;
      limit[vecs[v].idx*Size +: Size] = vecs[v].lim;
      req = vecs[v].onehot;
      push_run(vecs[v].onehot, vecs[v].lim, vecs[v].run_cycles);
      drain($sformatf("single%0d", v), 1'b0, 1'b1);
    end

    // All requesting with limit 1 from reset: owners 0,1,2,3,0 every 4 cycles.
    do_reset();
    limit = {5'd1, 5'd1, 5'd1, 5'd1};
    req   = 4'b1111;
    push_run(4'b0001, 5'd1, 2);
    push_run(4'b0010, 5'd1, 2);
    push_run(4'b0100, 5'd1, 2);
    push_run(4'b1000, 5'd1, 2);
    push_run(4'b0001, 5'd1, 2);
    drain("rr", 1'b1, 1'b0);
    req = '0;

    // Cancel at count 4.
    do_reset();
    limit = '0;
    limit[0 +: Size] = 5'd10;
    req = 4'b0001;
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(4'b0001, 1'b1, 4'b0, 5'(k)));
    drain("cancel_run", 1'b1, 1'b0);
    cancel = 1'b1;
    exp_q.push_back(mk(4'b0, 1'b0, 4'b0, 5'd4));
    drain("cancel_abort", 1'b1, 1'b0);
    cancel = 1'b0;
    req    = '0;
    exp_q.push_back(mk(4'b0, 1'b0, 4'b0, 5'd4));
    drain("cancel_hold", 1'b1, 1'b0);

    // Request withdrawn at count 4.
    req = 4'b0001;
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(4'b0001, 1'b1, 4'b0, 5'(k)));
    drain("drop_run", 1'b1, 1'b0);
    req = '0;
    exp_q.push_back(mk(4'b0, 1'b0, 4'b0, 5'd4));
    exp_q.push_back(mk(4'b0, 1'b0, 4'b0, 5'd4));
    drain("drop_abort", 1'b1, 1'b0);

    // Asynchronous reset at count 5, then pointer restarts at requester 0.
    req = 4'b0001;
    for (int k = 0; k < 6; k++) exp_q.push_back(mk(4'b0001, 1'b1, 4'b0, 5'(k)));
    drain("rst_run", 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_async", mk(4'b0, 1'b0, 4'b0, 5'd0));
    req = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    limit = '0;
    limit[1*Size +: Size] = 5'd1;
    limit[3*Size +: Size] = 5'd1;
    req = 4'b1010;
    push_run(4'b0010, 5'd1, 2);
    push_run(4'b1000, 5'd1, 2);
    drain("post_rst", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
